// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder
// Monitors a multiplexed seven-segment drive (segments + one-hot digitSelect),
// waits for each pattern to settle, decodes it back to a hex nibble and
// assembles a full word once every digit of a scan has been seen.
// Optional feature macro: SEVEN_SEG_ERR_COUNT_EN adds the saturating errorCount port.
// Handshake: wordValid and patternError are single-cycle pulses with no
// back-pressure; hexWord holds the last complete word and changes only in
// the cycle where wordValid is high.
module seven_segment_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              segments,
  input  logic [NUM_DIGITS-1:0]   digitSelect,
  output logic [4*NUM_DIGITS-1:0] hexWord,
  output logic                    wordValid,
  output logic                    patternError
`ifdef SEVEN_SEG_ERR_COUNT_EN
  ,
  output logic [7:0]              errorCount
`endif
);

  localparam int SW = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES);
  // The capture fires on the edge where the count would reach STABLE_CYCLES-1.
  localparam logic [CW-1:0] LAST_COUNT = CW'(STABLE_CYCLES - 2);
  localparam logic [6:0]    BLANK      = 7'h7F;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Active-low gfedcba to {valid, nibble}.
  function automatic logic [4:0] decode_seg(input logic [6:0] p);
    case (p)
      7'b1000000: decode_seg = {1'b1, 4'h0};
      7'b1111001: decode_seg = {1'b1, 4'h1};
      7'b0100100: decode_seg = {1'b1, 4'h2};
      7'b0110000: decode_seg = {1'b1, 4'h3};
      7'b0011001: decode_seg = {1'b1, 4'h4};
      7'b0010010: decode_seg = {1'b1, 4'h5};
      7'b0000010: decode_seg = {1'b1, 4'h6};
      7'b1111000: decode_seg = {1'b1, 4'h7};
      7'b0000000: decode_seg = {1'b1, 4'h8};
      7'b0010000: decode_seg = {1'b1, 4'h9};
      7'b0001000: decode_seg = {1'b1, 4'hA};
      7'b0000011: decode_seg = {1'b1, 4'hB};
      7'b1000110: decode_seg = {1'b1, 4'hC};
      7'b0100001: decode_seg = {1'b1, 4'hD};
      7'b0000110: decode_seg = {1'b1, 4'hE};
      7'b0001110: decode_seg = {1'b1, 4'hF};
      default:    decode_seg = 5'b0_0000;
    endcase
  endfunction

  // Registered state
  logic [SW-1:0]           sample_q, sample_d;
  logic [SW-1:0]           prev_q, prev_d;
  logic [CW-1:0]           count_q, count_d;
  state_e                  state_q, state_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] staging_q, staging_d;
  logic [4*NUM_DIGITS-1:0] hex_word_q, hex_word_d;
  logic                    err_pend_q, err_pend_d;
  logic                    done_pend_q, done_pend_d;
  logic                    word_valid_q, word_valid_d;
  logic                    pattern_error_q, pattern_error_d;

  // Combinational helpers
  logic [6:0]              seg_norm;
  logic                    same_sample;
  logic                    capture;
  logic [NUM_DIGITS-1:0]   cap_sel;
  logic [6:0]              cap_pat;
  logic [4:0]              cap_dec;
  logic                    sel_onehot;
  logic                    is_blank;
  logic [NUM_DIGITS-1:0]   mask_merged;

  // Input stage: normalise to active-low codes and build the sample history.
  always_comb begin
    seg_norm = (ACTIVE_LOW != 0) ? segments : ~segments;
    sample_d = {digitSelect, seg_norm};
    prev_d   = sample_q;
  end

  // Stability FSM: count identical samples, capture once, then hold until a change.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    capture     = 1'b0;
    same_sample = (sample_q == prev_q);
    if (state_q == ST_WAIT) begin
      if (!same_sample) begin
        count_d = '0;
      end else if (count_q == LAST_COUNT) begin
        capture = 1'b1;
        state_d = ST_HOLD;
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else begin
      if (!same_sample) begin
        state_d = ST_WAIT;
        count_d = '0;
      end
    end
  end

  // Capture rules, word completion and the pulse outputs (one cycle after capture).
  always_comb begin
    cap_sel         = sample_q[SW-1:7];
    cap_pat         = sample_q[6:0];
    cap_dec         = decode_seg(cap_pat);
    sel_onehot      = ($countones(cap_sel) == 1);
    is_blank        = (cap_pat == BLANK);
    mask_merged     = mask_q | cap_sel;
    mask_d          = mask_q;
    staging_d       = staging_q;
    hex_word_d      = hex_word_q;
    word_valid_d    = done_pend_q;
    pattern_error_d = err_pend_q;
    err_pend_d      = 1'b0;
    done_pend_d     = 1'b0;
    if (done_pend_q) begin
      hex_word_d = staging_q;
      mask_d     = '0;
    end
    if (capture) begin
      if (sel_onehot && cap_dec[4]) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (cap_sel[i]) staging_d[4*i +: 4] = cap_dec[3:0];
        end
        mask_d      = mask_merged;
        done_pend_d = &mask_merged;
      end else if (sel_onehot && is_blank) begin
        mask_d = mask_q & ~cap_sel;
      end else begin
        // Bad select or unknown glyph: abandon the partial scan.
        err_pend_d = 1'b1;
        mask_d     = '0;
      end
    end
  end

`ifdef SEVEN_SEG_ERR_COUNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of rejected captures.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_pend_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign errorCount = err_cnt_q;
`endif

  // State registers; reset overrides any capture in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q        <= '0;
      prev_q          <= '0;
      count_q         <= '0;
      state_q         <= ST_WAIT;
      mask_q          <= '0;
      staging_q       <= '0;
      hex_word_q      <= '0;
      err_pend_q      <= 1'b0;
      done_pend_q     <= 1'b0;
      word_valid_q    <= 1'b0;
      pattern_error_q <= 1'b0;
    end else begin
      sample_q        <= sample_d;
      prev_q          <= prev_d;
      count_q         <= count_d;
      state_q         <= state_d;
      mask_q          <= mask_d;
      staging_q       <= staging_d;
      hex_word_q      <= hex_word_d;
      err_pend_q      <= err_pend_d;
      done_pend_q     <= done_pend_d;
      word_valid_q    <= word_valid_d;
      pattern_error_q <= pattern_error_d;
    end
  end

  assign hexWord      = hex_word_q;
  assign wordValid    = word_valid_q;
  assign patternError = pattern_error_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Bench for seven_segment_decoder: an active-low instance and an active-high
// instance see the same (inverted) stimulus and are both compared against a
// run-length reference model of the display monitor.
module tb_seven_segment_decoder;

  localparam int         S       = 4;
  localparam logic [6:0] BLANK   = 7'h7F;
  localparam logic [6:0] BAD_PAT = 7'b1010101;
  localparam logic [6:0] BAD_ALT = 7'b1010110;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_a, seg_b;
  logic [3:0]  dsel;
  logic [15:0] hex_a, hex_b;
  logic        wv_a, wv_b, pe_a, pe_b;
`ifdef SEVEN_SEG_ERR_COUNT_EN
  logic [7:0]  ec_a, ec_b;
`endif

  // Clock
  always #5 clk = ~clk;

  seven_segment_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(S), .ACTIVE_LOW(1)) dut_a (
    .clk(clk), .reset(reset), .segments(seg_a), .digitSelect(dsel),
    .hexWord(hex_a), .wordValid(wv_a), .patternError(pe_a)
`ifdef SEVEN_SEG_ERR_COUNT_EN
    , .errorCount(ec_a)
`endif
  );

  seven_segment_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(S), .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .reset(reset), .segments(seg_b), .digitSelect(dsel),
    .hexWord(hex_b), .wordValid(wv_b), .patternError(pe_b)
`ifdef SEVEN_SEG_ERR_COUNT_EN
    , .errorCount(ec_b)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: a run of identical samples is captured once when it
  // reaches S samples. Reset leaves two zero samples in the history.
  logic [10:0] run_val;
  int          run_len;
  logic [3:0]  m_mask;
  logic [15:0] m_stage, m_word;
  logic        m_pend_done, m_pend_err, m_wv, m_pe;
  int          m_errcnt;
  int          exp_wv_cnt, exp_pe_cnt;
  int          obs_wv_a, obs_wv_b, obs_pe_a, obs_pe_b, cyc_bad;

  function automatic logic [6:0] seg_code(input int n);
    case (n)
      0: seg_code = 7'b1000000;   1: seg_code = 7'b1111001;
      2: seg_code = 7'b0100100;   3: seg_code = 7'b0110000;
      4: seg_code = 7'b0011001;   5: seg_code = 7'b0010010;
      6: seg_code = 7'b0000010;   7: seg_code = 7'b1111000;
      8: seg_code = 7'b0000000;   9: seg_code = 7'b0010000;
      10: seg_code = 7'b0001000;  11: seg_code = 7'b0000011;
      12: seg_code = 7'b1000110;  13: seg_code = 7'b0100001;
      14: seg_code = 7'b0000110;  default: seg_code = 7'b0001110;
    endcase
  endfunction

  task automatic classify(input logic [10:0] v);
    logic [3:0] sel;
    logic [6:0] pat;
    int idx, nib;
    sel = v[10:7];
    pat = v[6:0];
    idx = -1;
    nib = -1;
    if ($countones(sel) == 1)
      for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
    for (int n = 0; n < 16; n++) if (seg_code(n) == pat) nib = n;
    if (idx >= 0 && nib >= 0) begin
      m_stage[idx*4 +: 4] = 4'(nib);
      m_mask[idx] = 1'b1;
      if (m_mask == 4'hF) m_pend_done = 1'b1;
    end else if (idx >= 0 && pat == BLANK) begin
      m_mask[idx] = 1'b0;
    end else begin
      m_pend_err = 1'b1;
      m_mask = 4'h0;
    end
  endtask

  task automatic model_edge(input logic rst, input logic [3:0] sel, input logic [6:0] pat);
    if (rst) begin
      run_val = '0; run_len = 2;
      m_mask = '0; m_stage = '0; m_word = '0;
      m_pend_done = 1'b0; m_pend_err = 1'b0; m_wv = 1'b0; m_pe = 1'b0;
      m_errcnt = 0;
    end else begin
      m_wv = m_pend_done;
      m_pe = m_pend_err;
      if (m_pend_done) begin m_word = m_stage; m_mask = 4'h0; exp_wv_cnt++; end
      if (m_pend_err) begin exp_pe_cnt++; if (m_errcnt < 255) m_errcnt++; end
      m_pend_done = 1'b0;
      m_pend_err  = 1'b0;
      if (run_len == S) classify(run_val);
      if ({sel, pat} == run_val) run_len++;
      else begin run_val = {sel, pat}; run_len = 1; end
    end
  endtask

  // Driver: one clock with the given inputs; tallies pulses and model disagreement.
  task automatic step(input logic rst, input logic [3:0] sel, input logic [6:0] pat);
    reset = rst; dsel = sel; seg_a = pat; seg_b = ~pat;
    @(posedge clk);
    model_edge(rst, sel, pat);
    #1;
    if (wv_a === 1'b1) obs_wv_a++;
    if (wv_b === 1'b1) obs_wv_b++;
    if (pe_a === 1'b1) obs_pe_a++;
    if (pe_b === 1'b1) obs_pe_b++;
    if (hex_a !== m_word || wv_a !== m_wv || pe_a !== m_pe) cyc_bad++;
    if (hex_b !== m_word || wv_b !== m_wv || pe_b !== m_pe) cyc_bad++;
`ifdef SEVEN_SEG_ERR_COUNT_EN
    if (ec_a !== 8'(m_errcnt) || ec_b !== 8'(m_errcnt)) cyc_bad++;
`endif
  endtask

  task automatic hold(input logic [3:0] sel, input logic [6:0] pat, input int n);
    for (int i = 0; i < n; i++) step(1'b0, sel, pat);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 4'b0001, BLANK);
  endtask

  task automatic clear_obs();
    obs_wv_a = 0; obs_wv_b = 0; obs_pe_a = 0; obs_pe_b = 0;
    cyc_bad = 0; exp_wv_cnt = 0; exp_pe_cnt = 0;
  endtask

  task automatic test_reset();
    clear_obs();
    do_reset(3);
    checks++; if (hex_a !== 16'h0) begin failures++; $display("FAIL reset_hex_a: got %h want 0000", hex_a); end
    checks++; if (hex_b !== 16'h0) begin failures++; $display("FAIL reset_hex_b: got %h want 0000", hex_b); end
    checks++; if (wv_a !== 1'b0 || wv_b !== 1'b0) begin failures++; $display("FAIL reset_wv: got %b%b want 00", wv_a, wv_b); end
    checks++; if (pe_a !== 1'b0 || pe_b !== 1'b0) begin failures++; $display("FAIL reset_pe: got %b%b want 00", pe_a, pe_b); end
`ifdef SEVEN_SEG_ERR_COUNT_EN
    checks++; if (ec_a !== 8'd0 || ec_b !== 8'd0) begin failures++; $display("FAIL reset_ec: got %0d/%0d want 0", ec_a, ec_b); end
`endif
  endtask

  task automatic test_scan();
    do_reset(2);
    clear_obs();
    hold(4'b0001, seg_code(3), 6);
    hold(4'b0010, seg_code(10), 6);
    hold(4'b0100, seg_code(15), 6);
    hold(4'b1000, seg_code(0), 6);
    hold(4'b0001, BLANK, 6);
    checks++; if (hex_a !== 16'h0FA3) begin failures++; $display("FAIL scan_hex_a: got %h want 0fa3", hex_a); end
    checks++; if (hex_b !== 16'h0FA3) begin failures++; $display("FAIL scan_hex_b_active_high: got %h want 0fa3", hex_b); end
    checks++; if (obs_wv_a != 1 || obs_wv_b != 1) begin failures++; $display("FAIL scan_wv_pulses: got %0d/%0d want 1", obs_wv_a, obs_wv_b); end
    checks++; if (obs_pe_a != 0 || obs_pe_b != 0) begin failures++; $display("FAIL scan_pe_pulses: got %0d/%0d want 0", obs_pe_a, obs_pe_b); end
    checks++; if (cyc_bad != 0) begin failures++; $display("FAIL scan_cycles: got %0d bad cycles want 0", cyc_bad); end
  endtask

  task automatic test_glitch();
    do_reset(2);
    clear_obs();
    hold(4'b0001, seg_code(1), 6);
    hold(4'b0010, seg_code(2), 6);
    hold(4'b1000, seg_code(9), 3);
    hold(4'b0100, BAD_PAT, 3);
    hold(4'b0100, seg_code(3), 6);
    checks++; if (obs_wv_a + obs_pe_a != 0) begin failures++; $display("FAIL glitch_no_pulse: got %0d pulses want 0", obs_wv_a + obs_pe_a); end
    hold(4'b1000, seg_code(4), 6);
    hold(4'b0001, BLANK, 4);
    checks++; if (hex_a !== 16'h4321) begin failures++; $display("FAIL glitch_hex: got %h want 4321", hex_a); end
    checks++; if (obs_wv_a != 1 || obs_pe_a != 0) begin failures++; $display("FAIL glitch_pulses: got wv=%0d pe=%0d want 1/0", obs_wv_a, obs_pe_a); end
    checks++; if (cyc_bad != 0) begin failures++; $display("FAIL glitch_cycles: got %0d bad cycles want 0", cyc_bad); end
  endtask

  task automatic test_invalid();
    do_reset(2);
    clear_obs();
    hold(4'b0010, seg_code(7), 6);
    hold(4'b0100, seg_code(8), 6);
    hold(4'b1000, seg_code(9), 6);
    hold(4'b0001, BAD_PAT, 4);
    hold(4'b0001, seg_code(0), 6);
    checks++; if (obs_pe_a != 1 || obs_wv_a != 0) begin failures++; $display("FAIL invalid_first: got pe=%0d wv=%0d want 1/0", obs_pe_a, obs_wv_a); end
    hold(4'b0011, seg_code(5), 6);
    hold(4'b0000, seg_code(5), 6);
    hold(4'b0001, BLANK, 6);
    checks++; if (obs_pe_a != 3 || obs_pe_b != 3) begin failures++; $display("FAIL invalid_total: got %0d/%0d want 3", obs_pe_a, obs_pe_b); end
    checks++; if (hex_a !== 16'h0) begin failures++; $display("FAIL invalid_hex: got %h want 0000", hex_a); end
`ifdef SEVEN_SEG_ERR_COUNT_EN
    checks++; if (ec_a !== 8'd3 || ec_b !== 8'd3) begin failures++; $display("FAIL invalid_errcount: got %0d/%0d want 3", ec_a, ec_b); end
`endif
    checks++; if (cyc_bad != 0) begin failures++; $display("FAIL invalid_cycles: got %0d bad cycles want 0", cyc_bad); end
  endtask

  task automatic test_hold_long();
    do_reset(2);
    clear_obs();
    hold(4'b0100, seg_code(7), 100);
    hold(4'b0100, BLANK, 6);
    hold(4'b0001, seg_code(10), 6);
    hold(4'b0010, seg_code(11), 6);
    hold(4'b1000, seg_code(12), 6);
    checks++; if (obs_wv_a != 0 || obs_pe_a != 0) begin failures++; $display("FAIL blank_clears: got wv=%0d pe=%0d want 0/0", obs_wv_a, obs_pe_a); end
    hold(4'b0100, seg_code(7), 6);
    hold(4'b0100, BAD_PAT, 100);
    checks++; if (hex_a !== 16'hC7BA) begin failures++; $display("FAIL hold_hex: got %h want c7ba", hex_a); end
    checks++; if (obs_wv_a != 1 || obs_pe_a != 1) begin failures++; $display("FAIL hold_once: got wv=%0d pe=%0d want 1/1", obs_wv_a, obs_pe_a); end
    checks++; if (cyc_bad != 0) begin failures++; $display("FAIL hold_cycles: got %0d bad cycles want 0", cyc_bad); end
  endtask

  task automatic test_reset_mid();
    do_reset(2);
    clear_obs();
    hold(4'b0001, seg_code(5), 6);
    hold(4'b0010, seg_code(6), 6);
    do_reset(3);
    checks++; if (hex_a !== 16'h0) begin failures++; $display("FAIL midreset_hex: got %h want 0000", hex_a); end
    hold(4'b0001, seg_code(5), 6);
    hold(4'b0010, seg_code(6), 6);
    hold(4'b0100, seg_code(7), 6);
    hold(4'b1000, seg_code(8), 4);
    do_reset(2);  // lands on the edge that would capture the last digit
    checks++; if (obs_wv_a != 0 || hex_a !== 16'h0) begin failures++; $display("FAIL reset_dominates: got wv=%0d hex=%h want 0/0000", obs_wv_a, hex_a); end
    hold(4'b0001, seg_code(1), 6);
    hold(4'b0010, seg_code(2), 6);
    hold(4'b0100, seg_code(3), 6);
    hold(4'b1000, seg_code(4), 6);
    hold(4'b0001, BLANK, 3);
    checks++; if (hex_a !== 16'h4321 || hex_b !== 16'h4321) begin failures++; $display("FAIL midreset_word: got %h/%h want 4321", hex_a, hex_b); end
    checks++; if (obs_wv_a != 1) begin failures++; $display("FAIL midreset_wv: got %0d want 1", obs_wv_a); end
    checks++; if (cyc_bad != 0) begin failures++; $display("FAIL midreset_cycles: got %0d bad cycles want 0", cyc_bad); end
  endtask

  task automatic test_random();
    logic [3:0] one;
    logic [3:0] sel;
    logic [6:0] pat;
    int r;
    one = 4'b0001;
    do_reset(2);
    clear_obs();
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 9);
      if (r < 8) sel = one << $urandom_range(0, 3);
      else       sel = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 9);
      if (r < 7)       pat = seg_code($urandom_range(0, 15));
      else if (r == 7) pat = BLANK;
      else             pat = 7'($urandom_range(0, 127));
      hold(sel, pat, $urandom_range(1, 8));
    end
    hold(4'b0001, BLANK, 6);
    checks++; if (cyc_bad != 0) begin failures++; $display("FAIL random_cycles: got %0d bad cycles want 0", cyc_bad); end
    checks++; if (obs_wv_a != exp_wv_cnt || obs_wv_b != exp_wv_cnt) begin failures++; $display("FAIL random_wv: got %0d/%0d want %0d", obs_wv_a, obs_wv_b, exp_wv_cnt); end
    checks++; if (obs_pe_a != exp_pe_cnt || obs_pe_b != exp_pe_cnt) begin failures++; $display("FAIL random_pe: got %0d/%0d want %0d", obs_pe_a, obs_pe_b, exp_pe_cnt); end
    checks++; if (hex_a !== m_word) begin failures++; $display("FAIL random_hex: got %h want %h", hex_a, m_word); end
  endtask

`ifdef SEVEN_SEG_ERR_COUNT_EN
  task automatic test_err_saturate();
    do_reset(2);
    clear_obs();
    for (int i = 0; i < 260; i++) hold(4'b0001, (i % 2 == 0) ? BAD_PAT : BAD_ALT, 4);
    hold(4'b0001, BLANK, 6);
    checks++; if (ec_a !== 8'd255 || ec_b !== 8'd255) begin failures++; $display("FAIL err_saturate: got %0d/%0d want 255", ec_a, ec_b); end
    checks++; if (obs_pe_a != 260) begin failures++; $display("FAIL err_sat_pulses: got %0d want 260", obs_pe_a); end
  endtask
`endif

  initial begin
    clear_obs();
    test_reset();
    test_scan();
    test_glitch();
    test_invalid();
    test_hold_long();
    test_reset_mid();
    test_random();
`ifdef SEVEN_SEG_ERR_COUNT_EN
    test_err_saturate();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
